// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches to instruction
// memory, buffers in-order responses for decode and drains stale fetches on redirect.
module instruction_fetch_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc
);
   localparam int unsigned PW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

   typedef enum logic {RUN, DRAIN} state_e;

   state_e          state_q;
   logic [XLEN-1:0] fetch_pc_q, rsp_pc_q;
   logic [CW-1:0]   outstanding_q, drop_cnt_q, count_q;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [XLEN-1:0] buf_data_q [BUF_DEPTH];
   logic [XLEN-1:0] buf_pc_q   [BUF_DEPTH];

   logic [XLEN-1:0] redir_pc;
   logic            credit_ok, req_fire, push, pop;
   logic [CW-1:0]   outstanding_d, count_d, drop_d;

   assign redir_pc = redirect_pc & ~XLEN'(3);

   // Occupancy plus in-flight fetches never exceeds the buffer, so every
   // response is guaranteed a free slot.
   assign credit_ok = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW+1)'(BUF_DEPTH);

   assign imem_req_valid = reset && (state_q == RUN) && credit_ok && !redirect_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign push       = (state_q == RUN) && imem_rsp_valid && !redirect_valid;
   assign inst_valid = (count_q != '0);
   assign pop        = inst_valid && inst_ready && !redirect_valid;
   assign inst_data  = buf_data_q[rd_ptr_q];
   assign inst_pc    = buf_pc_q[rd_ptr_q];

   assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
   assign count_d       = count_q + CW'(push) - CW'(pop);
   // A response landing in the redirect cycle is already stale and is dropped here.
   assign drop_d        = outstanding_q - CW'(imem_rsp_valid);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            buf_data_q[i] <= '0;
            buf_pc_q[i]   <= '0;
         end
      end else begin
         outstanding_q <= outstanding_d;
         case (state_q)
            RUN: begin
               if (redirect_valid) begin
                  fetch_pc_q <= redir_pc;
                  rsp_pc_q   <= redir_pc;
                  count_q    <= '0;
                  wr_ptr_q   <= '0;
                  rd_ptr_q   <= '0;
                  drop_cnt_q <= drop_d;
                  if (drop_d != '0) state_q <= DRAIN;
               end else begin
                  if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(4);
                  if (push) begin
                     buf_data_q[wr_ptr_q] <= imem_rsp_data;
                     buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
                     wr_ptr_q             <= wr_ptr_q + 1'b1;
                     rsp_pc_q             <= rsp_pc_q + XLEN'(4);
                  end
                  if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                  count_q <= count_d;
               end
            end
            DRAIN: begin
               if (imem_rsp_valid) begin
                  drop_cnt_q <= drop_cnt_q - 1'b1;
                  if (drop_cnt_q == CW'(1)) state_q <= RUN;
               end
               if (redirect_valid) begin
                  fetch_pc_q <= redir_pc;
                  rsp_pc_q   <= redir_pc;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   // Memory may only answer requests it accepted; a response with nothing
   // outstanding (or nothing left to drop while draining) is a protocol bug.
   assert property (@(posedge clk) disable iff (!reset)
      imem_rsp_valid |-> (outstanding_q != '0) && ((state_q == RUN) || (drop_cnt_q != '0)));

endmodule
